// File: rtl/lsu_ctrl_if.sv
// Bundles for the load/store unit: core-side request/response and memory-side bus.
// The master modport is the side that issues requests.

interface lsu_core_if;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_funct3;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic        fault;

    modport master (
        output core_req, core_we, core_funct3, core_addr, core_wdata,
        input  stall, done, rdata, misalign, fault
    );
    modport slave (
        input  core_req, core_we, core_funct3, core_addr, core_wdata,
        output stall, done, rdata, misalign, fault
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: checks size/alignment, issues one word-aligned memory access,
// stalls the core until the memory answers or a timeout fires, and extends load data.

module lsu_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    lsu_core_if.slave  core,
    lsu_mem_if.master  mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [7:0]  r_cnt;
    logic        r_misalign;
    logic        r_fault;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misalign;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // Access check on the live core inputs; only consulted in the accepting cycle.
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        case (core.core_funct3)
            3'b000:  w_misalign = 1'b0;
            3'b001:  w_misalign = core.core_addr[0];
            3'b010:  w_misalign = (core.core_addr[1:0] != 2'b00);
            3'b100:  w_illegal  = core.core_we;
            3'b101: begin
                w_illegal  = core.core_we;
                w_misalign = core.core_addr[0];
            end
            default: w_illegal  = 1'b1;
        endcase
        if (w_illegal) begin
            w_misalign = 1'b0;
        end
    end

    assign w_accept  = (r_state == IDLE) && core.core_req;
    assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

    // Lane enables and replicated store data are derived from the latched request only.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {r_addr[1], 1'b0};
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
    end

    assign w_byte = 8'(mem.mem_rdata >> {r_addr[1:0], 3'b000});
    assign w_half = 16'(mem.mem_rdata >> {r_addr[1], 4'b0000});

    always_comb begin
        w_load = mem.mem_rdata;
        case (r_funct3[1:0])
            2'b00:   w_load = r_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = mem.mem_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (core.core_req) begin
                    w_next = (w_illegal || w_misalign) ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem.mem_ready || w_timeout) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Stall in IDLE is gated by reset so the core is released the moment reset asserts.
    always_comb begin
        core.stall    = 1'b0;
        core.done     = 1'b0;
        core.misalign = 1'b0;
        core.fault    = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_be    = 4'b0000;
        case (r_state)
            IDLE: core.stall = core.core_req & rst;
            REQ: begin
                core.stall  = 1'b1;
                mem.mem_req = 1'b1;
                mem.mem_we  = r_we;
                mem.mem_be  = w_be;
            end
            RESP: begin
                core.done     = 1'b1;
                core.misalign = r_misalign;
                core.fault    = r_fault;
            end
            default: core.stall = 1'b0;
        endcase
    end

    assign core.rdata    = r_rdata;
    assign mem.mem_addr  = {r_addr[31:2], 2'b00};
    assign mem.mem_wdata = w_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we       <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_cnt      <= 8'd0;
            r_misalign <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we       <= core.core_we;
                r_funct3   <= core.core_funct3;
                r_addr     <= core.core_addr;
                r_wdata    <= core.core_wdata;
                r_misalign <= w_misalign;
                r_fault    <= w_illegal;
                if (w_illegal || w_misalign) begin
                    r_rdata <= 32'd0;
                end
            end
            if (r_state == REQ) begin
                r_cnt <= r_cnt + 8'd1;
                // A ready in the final counted cycle still wins over the timeout.
                if (mem.mem_ready) begin
                    r_fault <= 1'b0;
                    r_rdata <= r_we ? 32'd0 : w_load;
                end else if (w_timeout) begin
                    r_fault <= 1'b1;
                    r_rdata <= 32'd0;
                end
            end else begin
                r_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: loads, stores, misaligned/illegal accesses,
// timeout, back-to-back requests and reset during a memory wait.

module tb_lsu_ctrl;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    lsu_core_if core_bus ();
    lsu_mem_if  mem_bus ();

    lsu_ctrl #(.TIMEOUT(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .core (core_bus.slave),
        .mem  (mem_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observations of the last access made by run_access.
    int          ob_lat;
    int          ob_req_cycles;
    logic        ob_stall0;
    logic        ob_stall_bad;
    logic        ob_unstable;
    logic        ob_flag_early;
    logic        ob_we;
    logic [3:0]  ob_be;
    logic [31:0] ob_addr;
    logic [31:0] ob_wdata;
    logic [31:0] ob_rdata;
    logic        ob_mis;
    logic        ob_flt;
    logic        ob_done_stall;
    logic        ob_idle_we;
    logic [3:0]  ob_idle_be;

    // Starts at a negedge with the DUT in IDLE; cycle 0 is the accepting cycle.
    // ready_at is the REQ-cycle index at which mem_ready rises (-1 = never).
    task automatic run_access(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int ready_at);
        core_bus.core_req    = 1'b1;
        core_bus.core_we     = we;
        core_bus.core_funct3 = f3;
        core_bus.core_addr   = addr;
        core_bus.core_wdata  = wdata;
        mem_bus.mem_ready    = (ready_at == 0);
        ob_lat = -1; ob_req_cycles = 0; ob_stall_bad = 1'b0; ob_unstable = 1'b0;
        ob_flag_early = 1'b0; ob_we = 1'b0; ob_be = 4'h0; ob_addr = 32'h0; ob_wdata = 32'h0;
        ob_rdata = 32'hx; ob_mis = 1'bx; ob_flt = 1'bx; ob_done_stall = 1'bx;
        #1;
        ob_stall0     = core_bus.stall;
        ob_flag_early = core_bus.done | core_bus.misalign | core_bus.fault | mem_bus.mem_req;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (core_bus.done) begin
                ob_lat        = cyc;
                ob_rdata      = core_bus.rdata;
                ob_mis        = core_bus.misalign;
                ob_flt        = core_bus.fault;
                ob_done_stall = core_bus.stall;
                break;
            end
            if (core_bus.misalign || core_bus.fault) ob_flag_early = 1'b1;
            if (mem_bus.mem_req) begin
                if (ob_req_cycles == 0) begin
                    ob_we = mem_bus.mem_we; ob_be = mem_bus.mem_be;
                    ob_addr = mem_bus.mem_addr; ob_wdata = mem_bus.mem_wdata;
                end else if (mem_bus.mem_we !== ob_we || mem_bus.mem_be !== ob_be ||
                             mem_bus.mem_addr !== ob_addr || mem_bus.mem_wdata !== ob_wdata) begin
                    ob_unstable = 1'b1;
                end
                if (core_bus.stall !== 1'b1) ob_stall_bad = 1'b1;
                // Scramble core inputs; the latched request must not follow them.
                core_bus.core_addr   = ~addr;
                core_bus.core_wdata  = ~wdata;
                core_bus.core_we     = ~we;
                core_bus.core_funct3 = 3'b010;
                mem_bus.mem_ready    = (ready_at >= 0) && (ob_req_cycles >= ready_at);
                ob_req_cycles++;
            end
        end
        core_bus.core_req = 1'b0;
        mem_bus.mem_ready = 1'b0;
        @(negedge clk);
        ob_idle_we = mem_bus.mem_we;
        ob_idle_be = mem_bus.mem_be;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        core_bus.core_req = 1'b0; core_bus.core_we = 1'b0; core_bus.core_funct3 = 3'b000;
        core_bus.core_addr = 32'h0; core_bus.core_wdata = 32'h0;
        mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = 32'h0;
        #3;
        n_tests++; if ({core_bus.stall, core_bus.done, core_bus.misalign, core_bus.fault} !== 4'b0) begin
            n_fail++; $display("FAIL reset_core_flags got=%b exp=0000",
                {core_bus.stall, core_bus.done, core_bus.misalign, core_bus.fault}); end
        n_tests++; if (core_bus.rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata got=%h exp=0", core_bus.rdata); end
        n_tests++; if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be} !== 6'b0) begin
            n_fail++; $display("FAIL reset_mem_ctl got=%b exp=000000",
                {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be}); end
        n_tests++; if ({mem_bus.mem_addr, mem_bus.mem_wdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_mem_data got=%h/%h exp=0/0", mem_bus.mem_addr, mem_bus.mem_wdata); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_word;
        mem_bus.mem_rdata = 32'hDEADBEEF;
        run_access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0);
        n_tests++; if (ob_lat !== 2) begin n_fail++; $display("FAIL lw_latency got=%0d exp=2", ob_lat); end
        n_tests++; if (ob_stall0 !== 1'b1 || ob_stall_bad || ob_done_stall !== 1'b0) begin n_fail++;
            $display("FAIL lw_stall got c0=%b req_bad=%b done=%b exp 1/0/0", ob_stall0, ob_stall_bad, ob_done_stall); end
        n_tests++; if (ob_req_cycles !== 1 || ob_flag_early) begin n_fail++;
            $display("FAIL lw_req_cycles got=%0d early=%b exp=1/0", ob_req_cycles, ob_flag_early); end
        n_tests++; if (ob_be !== 4'b1111 || ob_addr !== 32'h100 || ob_we !== 1'b0) begin n_fail++;
            $display("FAIL lw_bus got be=%b addr=%h we=%b exp 1111/100/0", ob_be, ob_addr, ob_we); end
        n_tests++; if (ob_rdata !== 32'hDEADBEEF || ob_mis !== 1'b0 || ob_flt !== 1'b0) begin n_fail++;
            $display("FAIL lw_result got=%h mis=%b flt=%b exp deadbeef/0/0", ob_rdata, ob_mis, ob_flt); end
    endtask

    task automatic test_load_sub;
        mem_bus.mem_rdata = 32'h80112233;
        run_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0);
        n_tests++; if (ob_be !== 4'b1000 || ob_addr !== 32'h100) begin n_fail++;
            $display("FAIL lb_bus got be=%b addr=%h exp 1000/100", ob_be, ob_addr); end
        n_tests++; if (ob_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_sext got=%h exp=ffffff80", ob_rdata); end
        run_access(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0);
        n_tests++; if (ob_rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu_zext got=%h exp=00000080", ob_rdata); end
        run_access(1'b0, 3'b000, 32'h0000_0100, 32'h0, 0);
        n_tests++; if (ob_rdata !== 32'h00000033 || ob_be !== 4'b0001) begin n_fail++;
            $display("FAIL lb_lane0 got=%h be=%b exp 00000033/0001", ob_rdata, ob_be); end
        run_access(1'b0, 3'b001, 32'h0000_0102, 32'h0, 0);
        n_tests++; if (ob_rdata !== 32'hFFFF8011 || ob_be !== 4'b1100) begin n_fail++;
            $display("FAIL lh_sext got=%h be=%b exp ffff8011/1100", ob_rdata, ob_be); end
        run_access(1'b0, 3'b101, 32'h0000_0102, 32'h0, 0);
        n_tests++; if (ob_rdata !== 32'h00008011) begin n_fail++; $display("FAIL lhu_zext got=%h exp=00008011", ob_rdata); end
    endtask

    task automatic test_store;
        run_access(1'b1, 3'b001, 32'h0000_0102, 32'h0000ABCD, 0);
        n_tests++; if (ob_we !== 1'b1 || ob_be !== 4'b1100 || ob_wdata !== 32'hABCDABCD) begin n_fail++;
            $display("FAIL sh_bus got we=%b be=%b wdata=%h exp 1/1100/abcdabcd", ob_we, ob_be, ob_wdata); end
        n_tests++; if (ob_lat !== 2 || ob_rdata !== 32'h0 || ob_flt !== 1'b0) begin n_fail++;
            $display("FAIL sh_done got lat=%0d rdata=%h flt=%b exp 2/0/0", ob_lat, ob_rdata, ob_flt); end
        n_tests++; if (ob_idle_we !== 1'b0 || ob_idle_be !== 4'b0000) begin n_fail++;
            $display("FAIL idle_bus got we=%b be=%b exp 0/0000", ob_idle_we, ob_idle_be); end
        run_access(1'b1, 3'b000, 32'h0000_0101, 32'h00000012, 0);
        n_tests++; if (ob_be !== 4'b0010 || ob_wdata !== 32'h12121212 || ob_addr !== 32'h100) begin n_fail++;
            $display("FAIL sb_bus got be=%b wdata=%h addr=%h exp 0010/12121212/100", ob_be, ob_wdata, ob_addr); end
        run_access(1'b1, 3'b010, 32'h0000_0104, 32'hCAFEF00D, 2);
        n_tests++; if (ob_be !== 4'b1111 || ob_wdata !== 32'hCAFEF00D || ob_addr !== 32'h104 || ob_unstable) begin
            n_fail++; $display("FAIL sw_bus got be=%b wdata=%h addr=%h unstable=%b exp 1111/cafef00d/104/0",
                ob_be, ob_wdata, ob_addr, ob_unstable); end
        n_tests++; if (ob_lat !== 4 || ob_req_cycles !== 3) begin n_fail++;
            $display("FAIL sw_wait got lat=%0d req=%0d exp 4/3", ob_lat, ob_req_cycles); end
    endtask

    task automatic test_misalign_illegal;
        mem_bus.mem_rdata = 32'h55AA55AA;
        run_access(1'b0, 3'b010, 32'h0000_0102, 32'h0, 0);
        n_tests++; if (ob_lat !== 1 || ob_mis !== 1'b1 || ob_flt !== 1'b0 || ob_req_cycles !== 0) begin n_fail++;
            $display("FAIL lw_misalign got lat=%0d mis=%b flt=%b req=%0d exp 1/1/0/0", ob_lat, ob_mis, ob_flt, ob_req_cycles); end
        n_tests++; if (ob_rdata !== 32'h0 || ob_flag_early) begin n_fail++;
            $display("FAIL misalign_rdata got=%h early=%b exp 0/0", ob_rdata, ob_flag_early); end
        run_access(1'b0, 3'b001, 32'h0000_0101, 32'h0, 0);
        n_tests++; if (ob_mis !== 1'b1 || ob_req_cycles !== 0) begin n_fail++;
            $display("FAIL lh_misalign got mis=%b req=%0d exp 1/0", ob_mis, ob_req_cycles); end
        run_access(1'b0, 3'b011, 32'h0000_0100, 32'h0, 0);
        n_tests++; if (ob_lat !== 1 || ob_flt !== 1'b1 || ob_mis !== 1'b0 || ob_req_cycles !== 0) begin n_fail++;
            $display("FAIL f3_011 got lat=%0d flt=%b mis=%b req=%0d exp 1/1/0/0", ob_lat, ob_flt, ob_mis, ob_req_cycles); end
        run_access(1'b1, 3'b100, 32'h0000_0100, 32'h0, 0);
        n_tests++; if (ob_flt !== 1'b1 || ob_req_cycles !== 0) begin n_fail++;
            $display("FAIL store_f3_100 got flt=%b req=%0d exp 1/0", ob_flt, ob_req_cycles); end
    endtask

    task automatic test_timeout;
        mem_bus.mem_rdata = 32'h0F0F0F0F;
        run_access(1'b0, 3'b010, 32'h0000_0200, 32'h0, 0);
        run_access(1'b0, 3'b010, 32'h0000_0300, 32'h0, -1);
        n_tests++; if (ob_req_cycles !== 16 || ob_lat !== 17) begin n_fail++;
            $display("FAIL timeout_len got req=%0d lat=%0d exp 16/17", ob_req_cycles, ob_lat); end
        n_tests++; if (ob_flt !== 1'b1 || ob_rdata !== 32'h0 || ob_mis !== 1'b0 || ob_unstable) begin n_fail++;
            $display("FAIL timeout_result got flt=%b rdata=%h mis=%b unstable=%b exp 1/0/0/0",
                ob_flt, ob_rdata, ob_mis, ob_unstable); end
        mem_bus.mem_rdata = 32'h11223344;
        run_access(1'b0, 3'b010, 32'h0000_0300, 32'h0, 15);
        n_tests++; if (ob_req_cycles !== 16 || ob_flt !== 1'b0 || ob_rdata !== 32'h11223344) begin n_fail++;
            $display("FAIL ready_at_limit got req=%0d flt=%b rdata=%h exp 16/0/11223344",
                ob_req_cycles, ob_flt, ob_rdata); end
    endtask

    task automatic test_back_to_back;
        core_bus.core_req = 1'b1; core_bus.core_we = 1'b0; core_bus.core_funct3 = 3'b010;
        core_bus.core_addr = 32'h40; mem_bus.mem_rdata = 32'h0BADF00D; mem_bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (core_bus.done !== 1'b1 || core_bus.rdata !== 32'h0BADF00D) begin n_fail++;
            $display("FAIL b2b_first got done=%b rdata=%h exp 1/0badf00d", core_bus.done, core_bus.rdata); end
        mem_bus.mem_rdata = 32'h13579BDF;
        @(negedge clk);
        n_tests++; if ({core_bus.done, mem_bus.mem_req, core_bus.stall} !== 3'b001) begin n_fail++;
            $display("FAIL b2b_gap got done/req/stall=%b exp 001", {core_bus.done, mem_bus.mem_req, core_bus.stall}); end
        @(negedge clk);
        n_tests++; if (mem_bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req got=%b exp=1", mem_bus.mem_req); end
        @(negedge clk);
        n_tests++; if (core_bus.done !== 1'b1 || core_bus.rdata !== 32'h13579BDF) begin n_fail++;
            $display("FAIL b2b_second got done=%b rdata=%h exp 1/13579bdf", core_bus.done, core_bus.rdata); end
        core_bus.core_req = 1'b0; mem_bus.mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic seen_done;
        core_bus.core_req = 1'b1; core_bus.core_we = 1'b0; core_bus.core_funct3 = 3'b010;
        core_bus.core_addr = 32'h200; mem_bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (mem_bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_wait got=%b exp=1", mem_bus.mem_req); end
        #2 rst = 1'b0;
        #1;
        n_tests++; if ({mem_bus.mem_req, core_bus.stall, core_bus.done} !== 3'b000) begin n_fail++;
            $display("FAIL rst_mid_drop got req/stall/done=%b exp 000", {mem_bus.mem_req, core_bus.stall, core_bus.done}); end
        seen_done = 1'b0;
        repeat (2) begin @(negedge clk); seen_done |= core_bus.done; end
        core_bus.core_req = 1'b0;
        rst = 1'b1;
        repeat (4) begin @(negedge clk); seen_done |= core_bus.done; end
        n_tests++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_done got=%b exp=0", seen_done); end
        mem_bus.mem_rdata = 32'h76543210;
        run_access(1'b0, 3'b010, 32'h0000_0204, 32'h0, 0);
        n_tests++; if (ob_lat !== 2 || ob_rdata !== 32'h76543210 || ob_flt !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_recover got lat=%0d rdata=%h flt=%b exp 2/76543210/0", ob_lat, ob_rdata, ob_flt); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_load_word();
        test_load_sub();
        test_store();
        test_misalign_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit between the core datapath and a variable-latency data memory. It accepts one load or store per request from the datapath (ALU address, rs2 store data, funct3), and checks the access for alignment and a legal size. It drives a word-aligned memory request with byte enables and stalls the core until the memory answers or a timeout expires. It returns sign- or zero-extended load data to the register write-back path.

## Interface
Parameters:
- TIMEOUT, default 16: maximum number of cycles in REQ without mem_ready before the access faults (1..255).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- core_req  in  1  access request; held high by the core until done.
- core_we  in  1  1 = store, 0 = load.
- core_funct3  in  3  RV32I size/sign code.
- core_addr  in  32  byte address (ALU result).
- core_wdata  in  32  store data (rs2).
- stall  out  1  freeze PC and register file write.
- done  out  1  one-cycle pulse marking the end of the access.
- rdata  out  32  extended load result; valid while done=1.
- misalign  out  1  with done: access misaligned; no memory traffic.
- fault  out  1  with done: illegal funct3 or memory timeout.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_be  out  4  byte-lane enables.
- mem_addr  out  32  word address ({addr[31:2],2'b00}).
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  memory completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read word.

## Operation
- FSM states:
  - IDLE: if core_req=1, latch we, funct3, addr and wdata, then check the access.
    - Illegal funct3 (011, 110, 111, or 1xx with we=1) → RESP with fault=1.
    - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0) → RESP with misalign=1.
    - Otherwise → REQ.
  - REQ: mem_req=1 and the timeout counter increments. On mem_ready=1, capture mem_rdata and go to RESP. When the counter reaches TIMEOUT, drop mem_req and go to RESP with fault=1.
  - RESP: done=1 for exactly one cycle, then IDLE.
- funct3 decoding: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned. Stores use 000, 001 or 010 only.
- mem_be:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
  - Loads drive the same mem_be as the equivalent store size, with mem_we=0.
- mem_wdata: byte stores replicate wdata[7:0] four times; half stores replicate wdata[15:0] twice; word stores pass wdata through unchanged.
- Load extraction:
  - Select the lane(s) indicated by addr[1:0].
  - Sign-extend for funct3 000/001; zero-extend for 100/101.
  - rdata is registered and holds until the next load completes.
  - Stores and faulted or misaligned accesses force rdata=0.
- stall = core_req & (state≠RESP) in IDLE; 1 in REQ; 0 in RESP.
- misalign and fault are only meaningful while done=1 and are 0 otherwise.
- mem_* outputs come from latched values, so they stay stable while mem_req=1 regardless of core input changes. When mem_req=0, mem_we=0 and mem_be=0.

## Timing
- Reset values (async, immediate): state=IDLE, all outputs 0 (stall, done, rdata, misalign, fault, mem_req, mem_we, mem_be, mem_addr, mem_wdata), counter=0.
- Minimum latency with mem_ready already high:
  - Cycle 0: core_req accepted in IDLE.
  - Cycle 1: mem_req asserted.
  - Cycle 2: done asserted.
  - stall is high in cycles 0–1.
- Misaligned or illegal access: done in cycle 1, with no mem_req ever asserted.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then RESP in the next cycle with fault=1.
- mem_ready is ignored outside REQ. A mem_ready arriving in the same cycle the counter hits TIMEOUT counts as success: no fault.
- core_req still high during RESP is not re-accepted. The next access is sampled in IDLE, one cycle after done.
- Reset asserted mid-REQ drops mem_req asynchronously. The in-flight access is abandoned and done is never issued.

## Test plan
- LW from addr 0x100 with mem_rdata=0xDEADBEEF, ready on the first REQ cycle → mem_be=1111, mem_addr=0x100, done in cycle 2 with rdata=0xDEADBEEF.
- LB from 0x103 with mem_rdata=0x80112233 → mem_be=1000, rdata=0xFFFFFF80. LBU from the same address → rdata=0x00000080. LHU from 0x102 → rdata=0x00008011.
- SH at 0x102 with wdata=0x0000ABCD → mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD. SB at 0x101 with wdata=0x12 → mem_be=0010, mem_wdata=0x12121212.
- LW at 0x102 → done in cycle 1 with misalign=1 and mem_req never high. funct3=011 → fault=1.
- mem_ready held low with TIMEOUT=16 → mem_req high for 16 cycles, then done with fault=1 and rdata=0.
- Reset pulled low during cycle 3 of a wait → mem_req and stall drop immediately. After release, a new LW completes normally.
